// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_multi register file.
package regfile_pkg;

  // Clear-engine FSM states.
  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} rf_state_t;

  // Parity helper operand width. Callers zero-extend narrower data to this width.
  // Zero-extension does not change the XOR reduction.
  localparam int PAR_MAX_W = 256;

  // Even-parity bit: set when the data has an odd number of ones.
  // With this bit appended, the stored word always has an even number of ones.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Bulk-clear engine for regfile_multi. The sweep starts when reset is
// released, or when clear_req is sampled in IDLE. The engine then writes
// zero to one entry per cycle, from entry 0 up to entry DEPTH-1.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] clr_cnt, cnt_nxt;

  // State and sweep-counter registers. Reset forces a fresh sweep from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the pre-edge values and the block order does not matter.
      state   <= state_nxt;
      clr_cnt <= cnt_nxt;
    end
  end

  // Next-state logic. A clear_req that arrives during a sweep is ignored.
  always_comb begin
    // NOTE: every output of this block gets a default first. That keeps
    // each path assigned, so no latch is inferred.
    state_nxt = state;
    cnt_nxt   = clr_cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = clr_cnt + AW'(1);
        if (clr_cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_cnt;

endmodule

// File: rtl/regfile_multi.sv
// Parametrised register file: two combinational read ports and one write
// port. The zero register and write-to-read bypass are both optional.
// A hardware bulk-clear engine zeroes the array after reset or on request.
// Define REGFILE_PARITY_EN to add per-entry even parity, with the ports
// err_inj, perr1 and perr2.
module regfile_multi
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_req,
  output logic             busy,
  input  logic             we3,
  input  logic [AW-1:0]    a3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
`ifdef REGFILE_PARITY_EN
  ,
  input  logic             err_inj,
  output logic             perr1,
  output logic             perr2
`endif
);

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_ok, zero1, zero2, byp1, byp2;

  regfile_clear_ctrl #(.DEPTH(DEPTH)) u_clear_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // A user write counts only in IDLE, and never to the hard-wired zero register.
  assign wr_ok = we3 && !busy && !((ZERO_REG != 0) && (a3 == '0));
  assign zero1 = (ZERO_REG != 0) && (a1 == '0);
  assign zero2 = (ZERO_REG != 0) && (a2 == '0);
  assign byp1  = (BYPASS != 0) && wr_ok && (a3 == a1);
  assign byp2  = (BYPASS != 0) && wr_ok && (a3 == a2);

`ifdef REGFILE_PARITY_EN
  logic par_mem [DEPTH];
  logic wr_par;

  assign wr_par = even_parity(PAR_MAX_W'(wd3)) ^ err_inj;

  // Storage write port. Clear-engine writes win; they write zero data with zero parity.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr]     <= '0;
      par_mem[clr_addr] <= 1'b0;
    end else if (wr_ok) begin
      mem[a3]     <= wd3;
      par_mem[a3] <= wr_par;
    end
  end

  // Parity check on the stored word. It is masked while busy, for the
  // zero register, and for bypassed reads.
  always_comb begin
    perr1 = 1'b0;
    perr2 = 1'b0;
    if (!busy) begin
      if (!zero1 && !byp1) perr1 = (even_parity(PAR_MAX_W'(mem[a1])) != par_mem[a1]);
      if (!zero2 && !byp2) perr2 = (even_parity(PAR_MAX_W'(mem[a2])) != par_mem[a2]);
    end
  end
`else
  // Storage write port. Clear-engine writes take priority over user writes.
  // NOTE: the array has no reset branch on purpose. Only the clear engine
  // zeroes it, so it can map onto plain RAM without a reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[a3] <= wd3;
    end
  end
`endif

  // Combinational read ports. Outputs are forced to zero while busy and for
  // the zero register; otherwise a same-cycle write is forwarded when bypass is enabled.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!busy) begin
      if (zero1)     rd1 = '0;
      else if (byp1) rd1 = wd3;
      else           rd1 = mem[a1];
      if (zero2)     rd2 = '0;
      else if (byp2) rd2 = wd3;
      else           rd2 = mem[a2];
    end
  end

endmodule

// File: tb/tb_regfile_multi.sv
// Self-checking bench for regfile_multi. Two instances share the same stimulus:
// dut0 uses the defaults (ZERO_REG=1, BYPASS=1), and dut1 uses ZERO_REG=0, BYPASS=0.
module tb_regfile_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        we3 = 1'b0;
  logic [4:0]  a3 = '0, a1 = '0, a2 = '0;
  logic [31:0] wd3 = '0;
  logic        busy0, busy1;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
`ifdef REGFILE_PARITY_EN
  logic        err_inj = 1'b0;
  logic        perr1_0, perr2_0, perr1_1, perr2_1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1_0, e2_0, e1_1, e2_1;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  regfile_multi dut0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy0),
    .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2), .rd1(rd1_0), .rd2(rd2_0)
`ifdef REGFILE_PARITY_EN
    , .err_inj(err_inj), .perr1(perr1_0), .perr2(perr2_0)
`endif
  );

  regfile_multi #(.ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1),
    .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2), .rd1(rd1_1), .rd2(rd2_1)
`ifdef REGFILE_PARITY_EN
    , .err_inj(err_inj), .perr1(perr1_1), .perr2(perr2_1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0x%08h expected queued entry", act);
    end else begin
      e = sb.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  // Count rising edges until busy drops, bounded so a stuck engine cannot hang the run.
  task automatic wait_busy_low(output int cnt);
    cnt = 0;
    while (busy0 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  // Drive one table vector at the falling edge and queue its expected reads.
  // Outputs are sampled before the next rising edge commits the write.
  task automatic run_vec(input int i);
    @(negedge clk);
    we3 = vecs[i].we;
    a3  = vecs[i].a3;
    wd3 = vecs[i].wd;
    a1  = vecs[i].a1;
    a2  = vecs[i].a2;
    sb_push($sformatf("vec%0d_rd1_dut0", i), vecs[i].e1_0);
    sb_push($sformatf("vec%0d_rd2_dut0", i), vecs[i].e2_0);
    sb_push($sformatf("vec%0d_rd1_dut1", i), vecs[i].e1_1);
    sb_push($sformatf("vec%0d_rd2_dut1", i), vecs[i].e2_1);
    #2;
    sb_pop(rd1_0);
    sb_pop(rd2_0);
    sb_pop(rd1_1);
    sb_pop(rd2_1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;

    //                 we    a3     wd             a1     a2     e1_0           e2_0           e1_1           e2_1
    vecs[0] = '{1'b1, 5'd9,  32'd1,         5'd9,  5'd31, 32'd1,         32'd0,         32'd0,         32'd0};
    vecs[1] = '{1'b1, 5'd31, 32'd3,         5'd9,  5'd31, 32'd1,         32'd3,         32'd1,         32'd0};
    vecs[2] = '{1'b1, 5'd0,  32'hDEADBEEF,  5'd0,  5'd31, 32'd0,         32'd3,         32'd0,         32'd3};
    vecs[3] = '{1'b0, 5'd0,  32'd0,         5'd0,  5'd9,  32'd0,         32'd1,         32'hDEADBEEF,  32'd1};
    vecs[4] = '{1'b1, 5'd9,  32'd123,       5'd31, 5'd9,  32'd3,         32'd123,       32'd3,         32'd1};
    vecs[5] = '{1'b0, 5'd0,  32'd0,         5'd9,  5'd0,  32'd123,       32'd0,         32'd123,       32'hDEADBEEF};
    vecs[6] = '{1'b1, 5'd17, 32'hA5A5A5A5,  5'd17, 5'd17, 32'hA5A5A5A5,  32'hA5A5A5A5,  32'd0,         32'd0};
    vecs[7] = '{1'b0, 5'd0,  32'd0,         5'd17, 5'd31, 32'hA5A5A5A5,  32'd3,         32'hA5A5A5A5,  32'd3};

    // Reset: hold for two cycles, then release. Busy should last exactly 32 edges.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy_dut0", busy0, 1);
    check("reset_busy_dut1", busy1, 1);
    check("reset_rd1_forced_zero", rd1_0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_busy_low(cnt);
    check("reset_busy_cycles", cnt, 32);
    check("reset_busy_low_dut1", busy1, 0);
    a1 = 5'd9;
    #1;
    check("post_reset_rd1_a9_dut0", rd1_0, 0);
    check("post_reset_rd1_a9_dut1", rd1_1, 0);

    // Table-driven write/read, zero-register and bypass vectors.
    for (int i = 0; i < 8; i++) run_vec(i);
    @(negedge clk);
    we3 = 1'b0;

`ifdef REGFILE_PARITY_EN
    // Parity: a corrupted write is flagged on a later read; a clean rewrite clears the flag.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'h7; err_inj = 1'b1; a1 = 5'd5; a2 = 5'd0;
    #2;
    check("par_bypassed_perr1_dut0", perr1_0, 0);
    check("par_old_perr1_dut1", perr1_1, 0);
    @(negedge clk);
    we3 = 1'b0; err_inj = 1'b0;
    #2;
    check("par_inj_perr1_dut0", perr1_0, 1);
    check("par_inj_perr1_dut1", perr1_1, 1);
    check("par_zero_reg_perr2_dut0", perr2_0, 0);
    @(negedge clk);
    we3 = 1'b1; wd3 = 32'h7; err_inj = 1'b0;
    @(negedge clk);
    we3 = 1'b0;
    #2;
    check("par_clean_perr1_dut0", perr1_0, 0);
    check("par_clean_perr1_dut1", perr1_1, 0);
`endif

    // Bulk clear: fill 1..31 with their index, then issue clear_req together with a write.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we3 = 1'b1; a3 = 5'(i); wd3 = 32'(i);
    end
    @(negedge clk);
    a1 = 5'd12; a2 = 5'd31;
    #1;
    check("fill_rd1_a12_dut1", rd1_1, 12);
    check("fill_rd2_a31_dut1", rd2_1, 31);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h77; clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    check("clear_busy_rise", busy0, 1);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hFFFFFFFF; a1 = 5'd5; a2 = 5'd31;
    #1;
    check("clear_rd1_forced_dut0", rd1_0, 0);
    check("clear_rd2_forced_dut1", rd2_1, 0);
    wait_busy_low(cnt);
    we3 = 1'b0;
    check("clear_busy_cycles", cnt - 1, 31);
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      #1;
      check($sformatf("cleared_rd1_dut0_%0d", i), rd1_0, 0);
      check($sformatf("cleared_rd2_dut0_%0d", 31 - i), rd2_0, 0);
      check($sformatf("cleared_rd1_dut1_%0d", i), rd1_1, 0);
    end

    // A clear_req during a sweep is ignored; reset at clr_cnt = 10 restarts the sweep.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd20; wd3 = 32'h1234;
    @(negedge clk);
    we3 = 1'b0; clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midclear_reset_busy", busy0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_busy_low(cnt);
    check("midclear_restart_cycles", cnt, 32);
    a1 = 5'd20;
    #1;
    check("midclear_rd1_a20_dut0", rd1_0, 0);
    check("midclear_rd1_a20_dut1", rd1_1, 0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
